// File: rtl/recip_nr_stream.sv
// Newton-Raphson reciprocal of a normalised mantissa x in [1,2): LUT seed, then iter_cnt refinement steps on one shared multiplier.
// Latency: 2 + 2*iter cycles from the accept edge to out_valid; an unnormalised operand goes straight to DONE on the accept edge.
// Backpressure: one operand in flight; in_ready only in IDLE; the result is held in DONE until out_ready.
// Ports:
//   CLK, RST           clock and synchronous active-high reset
//   in_valid/in_ready  operand handshake; din (1.(WL-1)) and iter_cnt are sampled on accept
//   out_valid/out_ready result handshake; dout (1.(WL-1)) and err are registered and held while stalled
module recip_nr_stream #(
   parameter int WL       = 24,
   parameter int LUT_ADDR = 6,
   parameter int LUT_BITS = 10,
   parameter int DWL      = 26,
   parameter int ITER_MAX = 3,
   parameter int IW       = $clog2(ITER_MAX + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WL-1:0] din,
   input  logic [IW-1:0] iter_cnt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [WL-1:0] dout,
   output logic          err
);

   // Extra fraction bits carried internally beyond the output word.
   localparam int SH    = DWL - WL;
   localparam int ROM_N = 1 << LUT_ADDR;
   // 1.0 in the output format, one bit wider so rounding overflow is visible.
   localparam logic [WL:0] ONE_W = (WL + 1)'(1) << (WL - 1);

   typedef enum logic [2:0] {
      IDLE,
      SEED,
      MUL_E,
      MUL_Y,
      ROUND,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [WL-1:0]   x_q, x_d;
   logic [DWL-1:0]  y_q, y_d;
   logic [DWL-1:0]  e_q, e_d;
   logic [IW-1:0]   cnt_q, cnt_d;
   logic [WL-1:0]   dout_q, dout_d;
   logic            err_q, err_d;

   // Seed for interval i is 1/(interval midpoint), rounded to LUT_BITS.
   function automatic int seed_val(input int i);
      int num;
      int den;
      num = 1 << (LUT_BITS + LUT_ADDR);
      den = (1 << (LUT_ADDR + 1)) + 2 * i + 1;
      return (2 * num + den) / (2 * den);
   endfunction

   logic [LUT_BITS-1:0] seed_rom [ROM_N];

   for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
      assign seed_rom[gi] = LUT_BITS'(seed_val(gi));
   end

   logic [DWL-1:0] seed_y;
   assign seed_y = {seed_rom[x_q[WL-2 -: LUT_ADDR]], {(DWL - LUT_BITS){1'b0}}};

   // Operands wider than ITER_MAX are quietly limited.
   logic [IW-1:0] iter_clamped;
   assign iter_clamped = (int'(iter_cnt) > ITER_MAX) ? IW'(ITER_MAX) : iter_cnt;

   // Single multiplier: x*y in MUL_E, y*(~e) in MUL_Y. Both operands are
   // 1.(DWL-1), so the product is 2.(2*DWL-2); keep the 1.(DWL-1) window.
   // Both products stay below 2, so the top bit is always zero.
   logic [DWL-1:0]   mul_a, mul_b, mul_trunc;
   logic [2*DWL-1:0] prod;

   assign mul_a     = y_q;
   assign mul_b     = (state_q == MUL_Y) ? ~e_q : {x_q, {SH{1'b0}}};
   assign prod      = {{DWL{1'b0}}, mul_a} * {{DWL{1'b0}}, mul_b};
   assign mul_trunc = prod[2*DWL-2 -: DWL];

   // Round to nearest, ties away from zero (y is positive, so add half an
   // output LSB), then clamp anything above 1.0.
   logic [DWL:0]  rnd_sum;
   logic [WL:0]   rnd_val;
   logic [WL-1:0] rnd_out;

   assign rnd_sum = {1'b0, y_q} + (DWL + 1)'(1 << (SH - 1));
   assign rnd_val = rnd_sum[DWL:SH];
   assign rnd_out = (rnd_val > ONE_W) ? ONE_W[WL-1:0] : rnd_val[WL-1:0];

   logic unused_bits;
   assign unused_bits = ^{prod[2*DWL-1], prod[DWL-2:0], rnd_sum[SH-1:0]};

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      e_d     = e_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d = din;
               if (!din[WL-1]) begin
                  cnt_d   = '0;
                  dout_d  = '0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  cnt_d   = iter_clamped;
                  state_d = SEED;
               end
            end
         end
         SEED: begin
            y_d     = seed_y;
            state_d = (cnt_q == '0) ? ROUND : MUL_E;
         end
         MUL_E: begin
            e_d     = mul_trunc;
            state_d = MUL_Y;
         end
         MUL_Y: begin
            y_d     = mul_trunc;
            cnt_d   = cnt_q - IW'(1);
            state_d = (cnt_q == IW'(1)) ? ROUND : MUL_E;
         end
         ROUND: begin
            dout_d  = rnd_out;
            err_d   = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         e_q     <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         e_q     <= e_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         err_q   <= err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign dout      = dout_q;
   assign err       = err_q;

endmodule
